// File: rtl/soc_system_cpu_cpu_debug_host_driver.sv
// Host-side driver for the Nios II debug-slave virtual-JTAG link.
// Runs one IR/data command through UIR, CDR, SDR, UDR and RTI and returns the captured tdo word.
module soc_system_cpu_cpu_debug_host_driver #(
    parameter int DATA_W  = 38,
    parameter int TCK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ir,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_ir_out,
    output logic              vji_tck,
    output logic              vji_tdi,
    input  logic              vji_tdo,
    output logic [1:0]        vji_ir_in,
    input  logic [1:0]        vji_ir_out,
    output logic              vji_uir,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_udr,
    output logic              vji_rti
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [7:0]       DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic              tck_q, tck_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [1:0]        ir_in_q, ir_in_d;
    logic [1:0]        ir_out_q, ir_out_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic active;
    logic tick;
    logic tck_rise;
    logic period_end;

    // A tck period is TCK_DIV clks low then TCK_DIV clks high; states advance when the high half ends.
    always_comb begin
        active     = state_q inside {S_UIR, S_CDR, S_SDR, S_UDR, S_RTI};
        tick       = active && (div_q == DIV_LAST);
        tck_rise   = tick && !tck_q;
        period_end = tick && tck_q;
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tck_d       = tck_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        cap_d       = cap_q;
        ir_in_d     = ir_in_q;
        ir_out_d    = ir_out_q;
        rsp_valid_d = rsp_valid_q;

        if (active) begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
            if (tick) begin
                tck_d = ~tck_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = S_UIR;
                    div_d   = 8'd0;
                    tck_d   = 1'b0;
                    bit_d   = '0;
                    shift_d = cmd_data;
                    cap_d   = '0;
                    ir_in_d = cmd_ir;
                end
            end
            S_UIR: begin
                if (tck_rise) begin
                    ir_out_d = vji_ir_out;
                end
                if (period_end) begin
                    state_d = S_CDR;
                end
            end
            S_CDR: begin
                if (period_end) begin
                    state_d = S_SDR;
                end
            end
            S_SDR: begin
                // Captured bits enter at the top so the first one ends up in bit 0.
                if (tck_rise) begin
                    cap_d = {vji_tdo, cap_q[DATA_W-1:1]};
                end
                if (period_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = S_UDR;
                    end else begin
                        bit_d   = bit_q + CNT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_UDR: begin
                if (period_end) begin
                    state_d = S_RTI;
                end
            end
            S_RTI: begin
                if (period_end) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            tck_q       <= 1'b0;
            bit_q       <= '0;
            shift_q     <= '0;
            cap_q       <= '0;
            ir_in_q     <= 2'b00;
            ir_out_q    <= 2'b00;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            ir_in_q     <= ir_in_d;
            ir_out_q    <= ir_out_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = cap_q;
    assign rsp_ir_out = ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = (state_q == S_SDR) && shift_q[0];
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = (state_q == S_UIR);
    assign vji_cdr    = (state_q == S_CDR);
    assign vji_sdr    = (state_q == S_SDR);
    assign vji_udr    = (state_q == S_UDR);
    assign vji_rti    = (state_q == S_RTI);

endmodule

// File: tb/tb_soc_system_cpu_cpu_debug_host_driver.sv
// Bench for the debug host driver: a timeline model predicts every output each clk,
// and directed sequences pin latency, edge counts, hold, reset-abort and ir_out capture.
module tb_soc_system_cpu_cpu_debug_host_driver;

    localparam int DATA_W   = 38;
    localparam int TCK_DIV  = 2;
    localparam int PER      = 2 * TCK_DIV;
    localparam int NPER     = DATA_W + 4;
    localparam int BUSY_CYC = NPER * PER;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_ir;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_ir_out;
    logic              vji_tck;
    logic              vji_tdi;
    logic              vji_tdo;
    logic [1:0]        vji_ir_in;
    logic [1:0]        vji_ir_out;
    logic              vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    int          checks = 0;
    int          errors = 0;
    int          tdo_mode;
    logic        tdo_rand;
    logic [1:0]  ir_out_drv;
    bit          cmp_en = 1'b0;
    int          tck_rises = 0;

    // Reference model state: cycles since accept, plus what a finished response must hold.
    bit                m_busy = 1'b0;
    bit                m_resp = 1'b0;
    bit                m_valid = 1'b0;
    bit                m_ready = 1'b0;
    int                m_c = 0;
    logic [DATA_W-1:0] m_cmd = '0;
    logic [DATA_W-1:0] m_cap = '0;
    logic [1:0]        m_ir_in = 2'b00;
    logic [1:0]        m_irout = 2'b00;

    always #5 clk = ~clk;

    assign vji_tdo    = (tdo_mode == 0) ? vji_tdi : (tdo_mode == 1) ? 1'b1 : tdo_rand;
    assign vji_ir_out = ir_out_drv;

    soc_system_cpu_cpu_debug_host_driver #(
        .DATA_W (DATA_W),
        .TCK_DIV(TCK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ir_out(rsp_ir_out),
        .vji_tck   (vji_tck),
        .vji_tdi   (vji_tdi),
        .vji_tdo   (vji_tdo),
        .vji_ir_in (vji_ir_in),
        .vji_ir_out(vji_ir_out),
        .vji_uir   (vji_uir),
        .vji_cdr   (vji_cdr),
        .vji_sdr   (vji_sdr),
        .vji_udr   (vji_udr),
        .vji_rti   (vji_rti)
    );

    always @(posedge vji_tck) tck_rises <= tck_rises + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tdoModel(input int k);
        if (tdo_mode == 0) return m_cmd[k];
        if (tdo_mode == 1) return 1'b1;
        return tdo_rand;
    endfunction

    // Model advances on each rising clk using the inputs presented before the edge.
    initial begin
        int nc;
        int p;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy  = 1'b0;
                m_resp  = 1'b0;
                m_valid = 1'b0;
                m_ready = 1'b0;
                m_cap   = '0;
                m_ir_in = 2'b00;
                m_irout = 2'b00;
            end else if (m_resp) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                end else if (rsp_ready) begin
                    m_valid = 1'b0;
                    m_resp  = 1'b0;
                    m_ready = 1'b1;
                end
            end else if (m_busy) begin
                nc = m_c + 1;
                if ((nc % PER) == TCK_DIV) begin
                    p = nc / PER;
                    if (p == 0) m_irout = ir_out_drv;
                    else if (p >= 2 && p < 2 + DATA_W) m_cap[p-2] = tdoModel(p - 2);
                end
                m_c = nc;
                if (m_c == BUSY_CYC) begin
                    m_busy = 1'b0;
                    m_resp = 1'b1;
                end
            end else begin
                if (cmd_valid && m_ready) begin
                    m_cmd   = cmd_data;
                    m_ir_in = cmd_ir;
                    m_cap   = '0;
                    m_c     = 0;
                    m_busy  = 1'b1;
                    m_ready = 1'b0;
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on each falling clk.
    initial begin
        int   p;
        logic e_tck;
        logic e_tdi;
        logic [4:0] e_strb;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_tck  = 1'b0;
                e_tdi  = 1'b0;
                e_strb = 5'b00000;
                if (m_busy) begin
                    p     = m_c / PER;
                    e_tck = (m_c % PER) >= TCK_DIV;
                    if (p == 0) e_strb = 5'b10000;
                    else if (p == 1) e_strb = 5'b01000;
                    else if (p < 2 + DATA_W) begin
                        e_strb = 5'b00100;
                        e_tdi  = m_cmd[p-2];
                    end
                    else if (p == 2 + DATA_W) e_strb = 5'b00010;
                    else e_strb = 5'b00001;
                end
                checkOutput("tck", vji_tck, e_tck);
                checkOutput("strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, e_strb);
                checkOutput("tdi", vji_tdi, e_tdi);
                checkOutput("ir_in", vji_ir_in, m_ir_in);
                checkOutput("cmd_ready", cmd_ready, m_ready);
                checkOutput("rsp_valid", rsp_valid, m_valid);
                if (m_valid) begin
                    checkOutput("rsp_data", rsp_data, m_cap);
                    checkOutput("rsp_ir_out", rsp_ir_out, m_irout);
                end
            end
        end
    end

    // Called on a falling clk; returns on the falling clk right after the accepting edge.
    task automatic applyStimulus(input logic [1:0] ir, input logic [DATA_W-1:0] data,
                                 input bit keep_valid, output bit ok);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput("accept_timeout", cmd_ready, 1);
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic waitResponse(output int lat, output int sdr_cycles);
        lat        = 0;
        sdr_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (vji_sdr) sdr_cycles++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) checkOutput("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic takeResponse;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        bit                ok;
        int                lat;
        int                sdr;
        int                rb;
        int                vcount;
        bit                done;
        logic [63:0]       rnd;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ir     = 2'b00;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        tdo_mode   = 0;
        tdo_rand   = 1'b0;
        ir_out_drv = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("reset_outputs",
                    {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
                     vji_udr, vji_rti, vji_ir_in, rsp_ir_out}, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", cmd_ready, 1);

        $display("[TB] loopback command with ir_out readback");
        ir_out_drv = 2'b10;
        rb = tck_rises;
        applyStimulus(2'b01, 38'h2A_5A5A_A5A5, 1'b0, ok);
        waitResponse(lat, sdr);
        checkOutput("loopback_latency", lat, 169);
        checkOutput("loopback_data", rsp_data, 38'h2A_5A5A_A5A5);
        checkOutput("ir_out_capture", rsp_ir_out, 2'b10);
        checkOutput("tck_rising_edges", tck_rises - rb, 42);
        checkOutput("sdr_clk_count", sdr, 38 * PER);
        repeat (50) @(negedge clk);
        checkOutput("hold_valid", rsp_valid, 1);
        checkOutput("hold_data", rsp_data, 38'h2A_5A5A_A5A5);
        checkOutput("hold_ready_low", cmd_ready, 0);
        takeResponse();
        checkOutput("handshake_valid_clear", rsp_valid, 0);
        checkOutput("handshake_ready", cmd_ready, 1);

        $display("[TB] tdo tied high");
        tdo_mode   = 1;
        ir_out_drv = 2'b01;
        rnd = {$urandom(), $urandom()};
        applyStimulus(2'b11, rnd[DATA_W-1:0], 1'b0, ok);
        waitResponse(lat, sdr);
        checkOutput("tdo_high_data", rsp_data, {DATA_W{1'b1}});
        checkOutput("tdo_high_ir_out", rsp_ir_out, 2'b01);
        takeResponse();

        $display("[TB] cmd_valid held through a command");
        tdo_mode = 0;
        rnd = {$urandom(), $urandom()};
        da  = rnd[DATA_W-1:0];
        rnd = {$urandom(), $urandom()};
        db  = rnd[DATA_W-1:0];
        applyStimulus(2'b10, da, 1'b1, ok);
        cmd_ir   = 2'b01;
        cmd_data = db;
        waitResponse(lat, sdr);
        checkOutput("held_first_data", rsp_data, da);
        checkOutput("held_ir_in", vji_ir_in, 2'b10);
        takeResponse();
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        waitResponse(lat, sdr);
        checkOutput("held_second_latency", lat, 169);
        checkOutput("held_second_data", rsp_data, db);
        checkOutput("held_second_ir_in", vji_ir_in, 2'b01);
        takeResponse();

        $display("[TB] reset during SDR bit 10");
        rnd = {$urandom(), $urandom()};
        applyStimulus(2'b01, rnd[DATA_W-1:0], 1'b0, ok);
        repeat ((2 + 10) * PER + 1) @(negedge clk);
        checkOutput("in_sdr_before_reset", vji_sdr, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_vji_zero",
                    {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}, 0);
        checkOutput("abort_ready_in_reset", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_after", cmd_ready, 1);
        vcount = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        checkOutput("abort_no_rsp", vcount, 0);

        $display("[TB] fresh command after abort");
        rnd = {$urandom(), $urandom()};
        da  = rnd[DATA_W-1:0];
        applyStimulus(2'b11, da, 1'b0, ok);
        waitResponse(lat, sdr);
        checkOutput("fresh_latency", lat, 169);
        checkOutput("fresh_data", rsp_data, da);
        takeResponse();

        $display("[TB] randomized commands");
        tdo_mode = 2;
        for (int n = 0; n < 6; n++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus(2'($urandom_range(0, 3)), rnd[DATA_W-1:0], 1'b0, ok);
            done = 1'b0;
            for (int i = 0; i < 2000 && !done; i++) begin
                if (cmd_ready) begin
                    done = 1'b1;
                end else begin
                    tdo_rand   = 1'($urandom_range(0, 1));
                    ir_out_drv = 2'($urandom_range(0, 3));
                    rsp_ready  = ($urandom_range(0, 3) == 0);
                    cmd_valid  = 1'($urandom_range(0, 1));
                    rnd        = {$urandom(), $urandom()};
                    cmd_data   = rnd[DATA_W-1:0];
                    @(negedge clk);
                end
            end
            checkOutput("rand_cmd_done", cmd_ready, 1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
